// File: rtl/i2c_slave_avalon.sv
// I2C slave (16x8 register file) with Avalon-MM CSR access; filtered SCL/SDA, open-drain SDA, no clock stretching.
// Avalon reads are combinational and waitrequest is never asserted; the I2C side follows SCL with ~6 clocks of filter delay.
module i2c_slave_avalon #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42,
    parameter int         FILTER_LEN = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    output logic        waitrequest,
    input  logic        scl,
    inout  wire         sda
);

    localparam int FW = $clog2(FILTER_LEN + 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8,
        IGNORE    = 4'd9
    } state_t;

    // Bit 0 carries SCL, bit 1 carries SDA through sync, filter and edge history.
    logic [1:0]    s1_q, s1_d, s2_q, s2_d, f_q, f_d, fp_q, fp_d;
    logic [FW-1:0] flt_cnt_q [2];
    logic [FW-1:0] flt_cnt_d [2];

    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        sda_oe_q, sda_oe_d;
    logic        rw_q, rw_d;
    logic        wrote_q, wrote_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [6:0]  own_addr_q, own_addr_d;
    logic [7:0]  wr_txn_count_q, wr_txn_count_d;
    logic [7:0]  regs_q [16];
    logic [7:0]  regs_d [16];

    logic       scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
    logic       i2c_we, txn_inc;
    logic [7:0] rx_byte;
    logic       unused_wdat;

    assign scl_f       = f_q[0];
    assign sda_f       = f_q[1];
    assign scl_rise    = scl_f & ~fp_q[0];
    assign scl_fall    = ~scl_f & fp_q[0];
    assign start_det   = fp_q[1] & ~sda_f & scl_f;
    assign stop_det    = ~fp_q[1] & sda_f & scl_f;
    assign rx_byte     = {shift_q[6:0], sda_f};
    assign sda         = sda_oe_q ? 1'b0 : 1'bz;
    assign waitrequest = 1'b0;
    assign unused_wdat = ^writedata[31:8];

    always_comb begin
        s1_d = {sda, scl};
        s2_d = s1_q;
        fp_d = f_q;
        f_d  = f_q;
        for (int i = 0; i < 2; i++) begin
            flt_cnt_d[i] = '0;
            if (s2_q[i] != f_q[i]) begin
                if (flt_cnt_q[i] == FW'(FILTER_LEN - 1)) f_d[i] = s2_q[i];
                else flt_cnt_d[i] = flt_cnt_q[i] + FW'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        sda_oe_d  = sda_oe_q;
        rw_d      = rw_q;
        wrote_d   = wrote_q;
        ptr_d     = ptr_q;
        i2c_we    = 1'b0;
        txn_inc   = 1'b0;
        if (start_det) begin
            state_d   = ADDR;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
        end else if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            txn_inc  = wrote_q;
            wrote_d  = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7 && state_q == PTR) ptr_d = rx_byte[3:0];
                        if (bit_cnt_q == 4'd7 && state_q == WDATA) begin
                            i2c_we  = 1'b1;
                            ptr_d   = ptr_q + 4'd1;
                            wrote_d = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        sda_oe_d  = 1'b1;
                        if (state_q == PTR) state_d = PTR_ACK;
                        else if (state_q == WDATA) state_d = WDATA_ACK;
                        else if (shift_q[7:1] == own_addr_q) begin
                            state_d = ADDR_ACK;
                            rw_d    = shift_q[0];
                        end else begin
                            state_d  = IGNORE;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                // ACK slots end on the falling edge that follows their own rising edge.
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_rise) bit_cnt_d = 4'd1;
                    else if (scl_fall && bit_cnt_q == 4'd1) begin
                        bit_cnt_d = 4'd0;
                        sda_oe_d  = 1'b0;
                        if (state_q == ADDR_ACK && rw_q) begin
                            state_d  = RDATA;
                            shift_d  = regs_q[ptr_q];
                            sda_oe_d = ~regs_q[ptr_q][7];
                        end else if (state_q == ADDR_ACK) state_d = PTR;
                        else state_d = WDATA;
                    end
                end
                RDATA: begin
                    if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
                    else if (scl_fall && bit_cnt_q == 4'd8) begin
                        state_d   = RDATA_ACK;
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        ptr_d     = ptr_q + 4'd1;
                    end else if (scl_fall) begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda_f) state_d = IGNORE;
                        else bit_cnt_d = 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        state_d   = RDATA;
                        bit_cnt_d = 4'd0;
                        shift_d   = regs_q[ptr_q];
                        sda_oe_d  = ~regs_q[ptr_q][7];
                    end
                end
                default: ;
            endcase
        end
    end

    // I2C register writes are applied after Avalon ones so they win a same-entry collision.
    always_comb begin
        regs_d     = regs_q;
        own_addr_d = own_addr_q;
        if (write && !address[4]) regs_d[address[3:0]] = writedata[7:0];
        if (write && address == 5'd16) own_addr_d = writedata[6:0];
        if (i2c_we) regs_d[ptr_q] = rx_byte;
        wr_txn_count_d = wr_txn_count_q + {7'b0, txn_inc};
        if (write && address == 5'd17) wr_txn_count_d = 8'd0;
    end

    always_comb begin
        readdata = 32'h0;
        if (read) begin
            if (!address[4]) readdata = {24'b0, regs_q[address[3:0]]};
            else if (address == 5'd16) readdata = {25'b0, own_addr_q};
            else if (address == 5'd17) readdata = {24'b0, wr_txn_count_q};
            else if (address == 5'd18) readdata = {27'b0, state_q, state_q != IDLE};
            else readdata = 32'hDEAD_BEEF;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_q           <= 2'b11;
            s2_q           <= 2'b11;
            f_q            <= 2'b11;
            fp_q           <= 2'b11;
            flt_cnt_q      <= '{default: '0};
            state_q        <= IDLE;
            bit_cnt_q      <= 4'd0;
            shift_q        <= 8'd0;
            sda_oe_q       <= 1'b0;
            rw_q           <= 1'b0;
            wrote_q        <= 1'b0;
            ptr_q          <= 4'd0;
            own_addr_q     <= SLAVE_ADDR;
            wr_txn_count_q <= 8'd0;
            regs_q         <= '{default: '0};
        end else begin
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            f_q            <= f_d;
            fp_q           <= fp_d;
            flt_cnt_q      <= flt_cnt_d;
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            sda_oe_q       <= sda_oe_d;
            rw_q           <= rw_d;
            wrote_q        <= wrote_d;
            ptr_q          <= ptr_d;
            own_addr_q     <= own_addr_d;
            wr_txn_count_q <= wr_txn_count_d;
            regs_q         <= regs_d;
        end
    end

endmodule

// File: tb/tb_i2c_slave_avalon.sv
// Directed bench for i2c_slave_avalon: bit-banged I2C master plus Avalon accesses.
module tb_i2c_slave_avalon;

    localparam int Q = 12;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        scl_m;
    logic        sda_m;
    wire         sda;

    pullup (sda);
    assign sda = sda_m ? 1'bz : 1'b0;

    i2c_slave_avalon dut (
        .clock       (clock),
        .reset       (reset),
        .address     (address),
        .write       (write),
        .writedata   (writedata),
        .read        (read),
        .readdata    (readdata),
        .waitrequest (waitrequest),
        .scl         (scl_m),
        .sda         (sda)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int low_cnt  = 0;
    logic mon_en = 1'b0;

    // Counts cycles where the bus is low although the master releases SDA.
    always @(negedge clock) begin
        if (mon_en && sda_m && !sda) low_cnt <= low_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic av_write(input logic [4:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        @(negedge clock);
        write = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] d;
        address = a; read = 1'b1;
        #1 d = readdata;
        read = 1'b0;
        check_eq(tag, d, exp);
    endtask

    // mode 1: Avalon write of 0 to regs[4] aligned with the slave's byte write; mode 2: 1-clock SDA low glitch.
    task automatic drive_bit(input logic b, input int mode, output logic smp);
        smp = 1'b1;
        tick(Q); sda_m = b;
        tick(Q); scl_m = 1'b1;
        for (int k = 1; k <= 2 * Q; k++) begin
            @(negedge clock);
            if (mode == 1 && k == 5) begin address = 5'd4; writedata = 32'h0; write = 1'b1; end
            if (mode == 1 && k == 6) write = 1'b0;
            if (mode == 2 && k == 4) sda_m = 1'b0;
            if (mode == 2 && k == 5) sda_m = 1'b1;
            if (k == Q) smp = sda;
        end
        scl_m = 1'b0;
    endtask

    task automatic start_cond();
        tick(Q); sda_m = 1'b1;
        tick(Q); scl_m = 1'b1;
        tick(Q); sda_m = 1'b0;
        tick(Q); scl_m = 1'b0;
    endtask

    task automatic stop_cond();
        tick(Q); sda_m = 1'b0;
        tick(Q); scl_m = 1'b1;
        tick(Q); sda_m = 1'b1;
        tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input int mode, input int mode_bit, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) drive_bit(b[i], (i == mode_bit) ? mode : 0, s);
        drive_bit(1'b1, 0, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            drive_bit(1'b1, 0, s);
            d[i] = s;
        end
        drive_bit(nack, 0, s);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic       ack;
        logic [7:0] d;
        int         low_before;
        reset = 1'b1; address = '0; write = 1'b0; writedata = '0; read = 1'b0;
        scl_m = 1'b1; sda_m = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(10);

        check_reg("rst_status", 5'd18, 32'h0);
        check_reg("rst_own_addr", 5'd16, 32'h42);
        check_reg("rst_count", 5'd17, 32'h0);
        check_reg("rst_reg0", 5'd0, 32'h0);
        check_reg("rst_reg15", 5'd15, 32'h0);
        check_reg("unmapped_read", 5'd20, 32'hDEAD_BEEF);
        check_eq("waitrequest", {31'b0, waitrequest}, 32'h0);
        check_eq("sda_idle", {31'b0, sda}, 32'h1);

        // Write S,0x84,0x03,0xAA,0xBB,P
        start_cond();
        send_byte(8'h84, 0, 0, ack); check_eq("wr_addr_ack", {31'b0, ack}, 32'h1);
        send_byte(8'h03, 0, 0, ack); check_eq("wr_ptr_ack", {31'b0, ack}, 32'h1);
        send_byte(8'hAA, 0, 0, ack); check_eq("wr_d0_ack", {31'b0, ack}, 32'h1);
        send_byte(8'hBB, 0, 0, ack); check_eq("wr_d1_ack", {31'b0, ack}, 32'h1);
        stop_cond(); tick(10);
        check_reg("wr_reg3", 5'd3, 32'hAA);
        check_reg("wr_reg4", 5'd4, 32'hBB);
        check_reg("wr_count", 5'd17, 32'h1);
        check_reg("wr_idle", 5'd18, 32'h0);

        // Read with pointer wrap 15 -> 0
        av_write(5'd15, 32'h5A);
        av_write(5'd0, 32'hC3);
        start_cond();
        send_byte(8'h84, 0, 0, ack); check_eq("rd_addr_ack", {31'b0, ack}, 32'h1);
        send_byte(8'h0F, 0, 0, ack); check_eq("rd_ptr_ack", {31'b0, ack}, 32'h1);
        start_cond();
        send_byte(8'h85, 0, 0, ack); check_eq("rd_raddr_ack", {31'b0, ack}, 32'h1);
        read_byte(1'b0, d); check_eq("rd_byte0", {24'b0, d}, 32'h5A);
        read_byte(1'b1, d); check_eq("rd_byte1", {24'b0, d}, 32'hC3);
        tick(Q); check_reg("rd_ignore", 5'd18, 32'h13);
        stop_cond(); tick(10);
        check_reg("rd_idle", 5'd18, 32'h0);
        check_reg("rd_count", 5'd17, 32'h1);

        // Address mismatch
        low_before = low_cnt;
        mon_en = 1'b1;
        start_cond();
        send_byte(8'h90, 0, 0, ack); check_eq("mm_addr_nack", {31'b0, ack}, 32'h0);
        send_byte(8'h01, 0, 0, ack);
        send_byte(8'h55, 0, 0, ack);
        stop_cond(); tick(10);
        mon_en = 1'b0;
        check_eq("mm_sda_low", low_cnt - low_before, 32'h0);
        check_reg("mm_reg1", 5'd1, 32'h0);
        check_reg("mm_count", 5'd17, 32'h1);

        // CSR side effects
        av_write(5'd17, 32'h0);
        check_reg("count_clear", 5'd17, 32'h0);
        av_write(5'd16, 32'hFFFF_FFC8);
        check_reg("own_addr_wr", 5'd16, 32'h48);
        av_write(5'd18, 32'hFFFF_FFFF);
        check_reg("status_ro", 5'd18, 32'h0);
        av_write(5'd25, 32'h1234_5678);
        check_reg("unmapped_wr", 5'd25, 32'hDEAD_BEEF);

        // New own address 0x48
        start_cond();
        send_byte(8'h90, 0, 0, ack); check_eq("na_addr_ack", {31'b0, ack}, 32'h1);
        send_byte(8'h01, 0, 0, ack); check_eq("na_ptr_ack", {31'b0, ack}, 32'h1);
        send_byte(8'h11, 0, 0, ack); check_eq("na_d_ack", {31'b0, ack}, 32'h1);
        stop_cond(); tick(10);
        check_reg("na_reg1", 5'd1, 32'h11);
        check_reg("na_count", 5'd17, 32'h1);
        av_write(5'd16, 32'h42);

        // Same-cycle Avalon/I2C write to regs[4]
        start_cond();
        send_byte(8'h84, 0, 0, ack);
        send_byte(8'h04, 0, 0, ack);
        send_byte(8'h77, 1, 0, ack); check_eq("col_ack", {31'b0, ack}, 32'h1);
        stop_cond(); tick(10);
        check_reg("col_reg4", 5'd4, 32'h77);
        check_reg("col_count", 5'd17, 32'h2);

        // SDA glitch while SCL high inside a data bit
        start_cond();
        send_byte(8'h84, 0, 0, ack);
        send_byte(8'h05, 0, 0, ack);
        send_byte(8'hFF, 2, 7, ack); check_eq("gl_ack", {31'b0, ack}, 32'h1);
        stop_cond(); tick(10);
        check_reg("gl_reg5", 5'd5, 32'hFF);
        check_reg("gl_count", 5'd17, 32'h3);

        // Reset while the slave drives a 0 data bit
        av_write(5'd2, 32'h12);
        start_cond();
        send_byte(8'h84, 0, 0, ack);
        send_byte(8'h02, 0, 0, ack);
        start_cond();
        send_byte(8'h85, 0, 0, ack);
        tick(Q);
        check_eq("rst_rd_drive", {31'b0, sda}, 32'h0);
        reset = 1'b1;
        #1 check_eq("rst_sda_rel", {31'b0, sda}, 32'h1);
        check_reg("rst_mid_state", 5'd18, 32'h0);
        check_reg("rst_mid_reg2", 5'd2, 32'h0);
        check_reg("rst_mid_reg4", 5'd4, 32'h0);
        check_reg("rst_mid_count", 5'd17, 32'h0);
        tick(2);
        reset = 1'b0;
        stop_cond(); tick(10);
        check_reg("post_rst_idle", 5'd18, 32'h0);
        check_eq("post_rst_sda", {31'b0, sda}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2c_slave_avalon.md
I2C_SLAVE_AVALON -- requirements
Module: i2c_slave_avalon

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h42, power-on 7-bit I2C device address.
REQ-002 SHALL have parameter FILTER_LEN, default 3, number of consecutive equal samples needed to accept a new SCL/SDA level.
REQ-003 SHALL have port clock, input, 1, system clock; clock ≥ 20× SCL rate.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port address, input, 5, Avalon word address.
REQ-006 SHALL have ports write (input, 1) and writedata (input, 32), Avalon write strobe and data.
REQ-007 SHALL have ports read (input, 1) and readdata (output, 32), Avalon read strobe and data.
REQ-008 SHALL have port waitrequest, output, 1, tied 0.
REQ-009 SHALL have port scl, input, 1, I2C clock; no clock stretching.
REQ-010 SHALL have port sda, inout, 1, open-drain: driven 0 or high-Z, never driven 1.

Function
REQ-011 SHALL pass scl and sda through a 2-FF synchronizer, then a FILTER_LEN-sample stable filter; all protocol decisions use the filtered levels (scl_f, sda_f).
REQ-012 SHALL detect START as an sda_f falling edge while scl_f=1, and STOP as an sda_f rising edge while scl_f=1.
REQ-013 SHALL sample data bits on scl_f rising edges, MSB first, and change its driven SDA only on scl_f falling edges.
REQ-014 SHALL hold a 16×8 register file regs[0..15], a 4-bit pointer ptr, a 7-bit own_addr, and an 8-bit wr_txn_count.
REQ-015 SHALL use FSM states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-016 START in any state SHALL go to ADDR, release SDA, and clear the bit counter (this covers repeated START).
REQ-017 STOP in any state SHALL go to IDLE and release SDA; if the transaction wrote ≥1 data byte, wr_txn_count SHALL increment, wrapping 255→0.
REQ-018 In ADDR, after 8 bits: {addr[6:0]} == own_addr SHALL go to ADDR_ACK and drive SDA 0 for the ACK bit; a mismatch SHALL go to IGNORE with SDA released.
REQ-019 From ADDR_ACK: R/W=0 SHALL go to PTR; R/W=1 SHALL load the shift register with regs[ptr], go to RDATA, and drive bit 7 at that scl_f falling edge.
REQ-020 The PTR byte SHALL set ptr = byte[3:0] (bits 7:4 ignored), then go to PTR_ACK (ACK driven), then WDATA.
REQ-021 Each WDATA byte SHALL write regs[ptr] on the 8th scl_f rising edge, then ptr increments mod 16 (15→0), then WDATA_ACK (ACK driven), then WDATA.
REQ-022 RDATA SHALL shift out regs[ptr] and increment ptr mod 16 after the 8th bit, then RDATA_ACK with SDA released.
REQ-023 In RDATA_ACK, master ACK (sda_f=0) SHALL reload the next byte and return to RDATA; master NACK SHALL go to IGNORE.
REQ-024 IGNORE SHALL keep SDA released until START or STOP.
REQ-025 Avalon map: readdata SHALL be available combinationally, same cycle as read:
- 0–15: {24'b0, regs[n]}, read/write
- 16: {25'b0, own_addr}, read/write (writedata[6:0])
- 17: {24'b0, wr_txn_count}; any write clears it
- 18: {27'b0, state_code[3:0], busy}, read-only; busy = state ≠ IDLE
- other addresses: read 32'hDEAD_BEEF, writes ignored
REQ-026 If an Avalon write and an I2C write target the same regs entry in the same cycle, the I2C write SHALL win.
REQ-027 If an Avalon clear of wr_txn_count coincides with an increment, the result SHALL be 0.
REQ-028 An own_addr write during a transaction SHALL take effect at the next ADDR comparison.

Reset
REQ-029 On reset, asynchronously: state=IDLE; SDA released; regs all 0; ptr=0; own_addr=SLAVE_ADDR; wr_txn_count=0; synchronizers and filters preset to 1.
REQ-030 Reset asserted mid-transaction SHALL release SDA immediately; after deassertion the block SHALL ignore bus activity until the next START.

Verification
REQ-031 Write sequence: S,0x84,0x03,0xAA,0xBB,P -> all bytes ACKed; regs[3]=0xAA, regs[4]=0xBB; Avalon 17 reads 1.
REQ-032 Read sequence: preload regs[15]=0x5A, regs[0]=0xC3 via Avalon; send S,0x84,0x0F,Sr,0x85, master ACKs then NACKs -> reads 0x5A then 0xC3 (pointer wraps); ends in IGNORE; P returns IDLE.
REQ-033 Address mismatch: S,0x90,… -> SDA never driven low; regs unchanged; count unchanged.
REQ-034 Avalon write own_addr=0x48, then S,0x90,0x01,0x11,P -> ACKed; regs[1]=0x11.
REQ-035 Glitch and collision: a 1-clock SDA pulse while SCL is high -> no START/STOP detected; an Avalon write to regs[4]=0x00 in the same cycle as an I2C write of 0x77 -> regs[4]=0x77.
REQ-036 Reset pulse during RDATA while driving 0 -> SDA high-Z within 1 clock; state=IDLE; regs=0.
